// File: rtl/fetch_ctrl.sv
// fetch_ctrl -- fetch-stage controller for the 5-stage MIPS pipeline.
// Owns the PC and the IF/ID pipeline register. It applies the hazard-unit stall
// and decode-stage branch redirects to them. There is no delay slot: the fetch
// behind a taken branch is squashed, which costs one bubble cycle.
//
// Parameters:
//   RESET_PC      PC loaded on reset
//   MAX_STALL     consecutive stalled cycles before StallTimeout sets (1..255)
// Ports:
//   Clk                 rising-edge clock
//   Reset               asynchronous active-low reset
//   Stall               hazard-unit hold request (ignored on an invalid slot)
//   BranchTaken         decode-stage redirect request
//   BranchTarget        redirect address
//   Instruction         instruction memory data at PC
//   PC                  current fetch address
//   IF_ID_Instruction   IF/ID instruction
//   IF_ID_PCPlus4       IF/ID PC+4
//   IF_ID_Valid         IF/ID holds a real instruction
//   ID_EX_Bubble        zero the ID/EX controls this cycle
//   StallTimeout        sticky stall watchdog flag
//   StallCycles         stalled-cycle counter (STALL_PERF_EN only, else 0)
//   FlushCount          redirect counter      (STALL_PERF_EN only, else 0)
// Build option: define STALL_PERF_EN to instantiate the performance counters.
module fetch_ctrl #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int unsigned MAX_STALL = 15
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        Stall,
   input  logic        BranchTaken,
   input  logic [31:0] BranchTarget,
   input  logic [31:0] Instruction,
   output logic [31:0] PC,
   output logic [31:0] IF_ID_Instruction,
   output logic [31:0] IF_ID_PCPlus4,
   output logic        IF_ID_Valid,
   output logic        ID_EX_Bubble,
   output logic        StallTimeout,
   output logic [31:0] StallCycles,
   output logic [31:0] FlushCount
);

   typedef enum logic [1:0] {S_RUN, S_STALL, S_FLUSH} state_e;

   localparam logic [7:0] MAX_STALL_C = 8'(MAX_STALL);

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] pc4_q, pc4_d;
   logic        valid_q, valid_d;
   logic [7:0]  cnt_q, cnt_d;
   logic        timeout_q, timeout_d;
   logic        stall_eff;
   logic [31:0] pc_plus4;

   // A squashed slot decodes as a nop with rs=rt=0, which would falsely match
   // a hazard, so a stall request only counts while IF/ID is valid.
   assign stall_eff = Stall & valid_q;
   assign pc_plus4  = pc_q + 32'd4;

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      instr_d = instr_q;
      pc4_d   = pc4_q;
      valid_d = valid_q;
      cnt_d   = '0;
      unique case (state_q)
         // STALL releases by behaving exactly as RUN, so the two share one arm.
         S_RUN, S_STALL: begin
            if (stall_eff) begin
               cnt_d   = (cnt_q == MAX_STALL_C) ? cnt_q : cnt_q + 8'd1;
               state_d = S_STALL;
            end else if (BranchTaken) begin
               pc_d    = BranchTarget;
               instr_d = '0;
               pc4_d   = '0;
               valid_d = 1'b0;
               state_d = S_FLUSH;
            end else begin
               pc_d    = pc_plus4;
               instr_d = Instruction;
               pc4_d   = pc_plus4;
               valid_d = 1'b1;
               state_d = S_RUN;
            end
         end
         // Decode holds the squashed nop, so any BranchTaken here is stale.
         S_FLUSH: begin
            pc_d    = pc_plus4;
            instr_d = Instruction;
            pc4_d   = pc_plus4;
            valid_d = 1'b1;
            state_d = S_RUN;
         end
         default: state_d = S_RUN;
      endcase
      timeout_d = timeout_q | (cnt_d == MAX_STALL_C);
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state_q   <= S_RUN;
         pc_q      <= RESET_PC;
         instr_q   <= '0;
         pc4_q     <= '0;
         valid_q   <= 1'b0;
         cnt_q     <= '0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         instr_q   <= instr_d;
         pc4_q     <= pc4_d;
         valid_q   <= valid_d;
         cnt_q     <= cnt_d;
         timeout_q <= timeout_d;
      end
   end

   assign PC                = pc_q;
   assign IF_ID_Instruction = instr_q;
   assign IF_ID_PCPlus4     = pc4_q;
   assign IF_ID_Valid       = valid_q;
   assign ID_EX_Bubble      = stall_eff | ~valid_q;
   assign StallTimeout      = timeout_q;

`ifdef STALL_PERF_EN
   logic [31:0] stall_cyc_q, flush_cnt_q;
   logic        redirect;

   assign redirect = (state_q != S_FLUSH) & ~stall_eff & BranchTaken;

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         stall_cyc_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         if (stall_eff) stall_cyc_q <= stall_cyc_q + 32'd1;
         if (redirect)  flush_cnt_q <= flush_cnt_q + 32'd1;
      end
   end

   assign StallCycles = stall_cyc_q;
   assign FlushCount  = flush_cnt_q;
`else
   assign StallCycles = '0;
   assign FlushCount  = '0;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
module tb_fetch_ctrl;
   localparam logic [31:0] RPC  = 32'h0000_0040;
   localparam int          MAXS = 15;

   logic        Clk = 1'b0;
   logic        Reset, Stall, BranchTaken;
   logic [31:0] BranchTarget, Instruction;
   logic [31:0] PC, IF_ID_Instruction, IF_ID_PCPlus4, StallCycles, FlushCount;
   logic        IF_ID_Valid, ID_EX_Bubble, StallTimeout;

   int nchk = 0;
   int nfail = 0;

   fetch_ctrl #(.RESET_PC(RPC), .MAX_STALL(MAXS)) dut (
      .Clk(Clk), .Reset(Reset), .Stall(Stall), .BranchTaken(BranchTaken),
      .BranchTarget(BranchTarget), .Instruction(Instruction), .PC(PC),
      .IF_ID_Instruction(IF_ID_Instruction), .IF_ID_PCPlus4(IF_ID_PCPlus4),
      .IF_ID_Valid(IF_ID_Valid), .ID_EX_Bubble(ID_EX_Bubble),
      .StallTimeout(StallTimeout), .StallCycles(StallCycles), .FlushCount(FlushCount)
   );

   always #5 Clk = ~Clk;

   // Instruction memory: a fixed scramble of the fetch address.
   function automatic logic [31:0] imem(input logic [31:0] a);
      return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
   endfunction

   assign Instruction = imem(PC);

   // Reference model of the architectural state.
   logic [31:0] m_pc, m_ins, m_pc4, m_sc, m_fc;
   logic        m_valid, m_to;
   bit          m_redirected;   // previous edge was a taken redirect
   int          m_run;          // consecutive stalled edges

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nchk++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_pc = RPC; m_ins = '0; m_pc4 = '0; m_valid = 1'b0; m_to = 1'b0;
      m_sc = '0; m_fc = '0; m_redirected = 0; m_run = 0;
   endtask

   task automatic check_all();
      chk("pc", PC, m_pc);
      chk("ifid_instr", IF_ID_Instruction, m_ins);
      chk("ifid_pc4", IF_ID_PCPlus4, m_pc4);
      chk("ifid_valid", {31'b0, IF_ID_Valid}, {31'b0, m_valid});
      chk("timeout", {31'b0, StallTimeout}, {31'b0, m_to});
`ifdef STALL_PERF_EN
      chk("stall_cycles", StallCycles, m_sc);
      chk("flush_count", FlushCount, m_fc);
`else
      chk("stall_cycles", StallCycles, 32'd0);
      chk("flush_count", FlushCount, 32'd0);
`endif
   endtask

   // One clock cycle: drive at negedge, check bubble, advance model, check after edge.
   task automatic step(input bit s, input bit b, input logic [31:0] t);
      logic stq;
      Stall = s; BranchTaken = b; BranchTarget = t;
      #1;
      stq = s & m_valid;
      chk("bubble", {31'b0, ID_EX_Bubble}, {31'b0, stq | ~m_valid});
      if (stq) begin
         if (m_run < MAXS) m_run++;
         if (m_run == MAXS) m_to = 1'b1;
         m_sc = m_sc + 32'd1;
      end else begin
         m_run = 0;
         if (b && !m_redirected) begin
            m_pc = t; m_ins = '0; m_pc4 = '0; m_valid = 1'b0;
            m_fc = m_fc + 32'd1;
            m_redirected = 1;
         end else begin
            m_ins = imem(m_pc); m_pc4 = m_pc + 32'd4; m_pc = m_pc + 32'd4;
            m_valid = 1'b1;
            m_redirected = 0;
         end
      end
      @(posedge Clk);
      @(negedge Clk);
      check_all();
   endtask

   // Asynchronous reset asserted mid-cycle, held across one edge.
   task automatic do_reset();
      Reset = 1'b0; Stall = 1'b0; BranchTaken = 1'b0; BranchTarget = '0;
      #1;
      model_reset();
      check_all();
      chk("reset_bubble", {31'b0, ID_EX_Bubble}, 32'd1);
      @(posedge Clk);
      @(negedge Clk);
      check_all();
      Reset = 1'b1;
   endtask

   initial begin
      Reset = 1'b1; Stall = 1'b0; BranchTaken = 1'b0; BranchTarget = '0;
      model_reset();
      @(negedge Clk);
      do_reset();
      chk("reset_pc", PC, 32'h40);

      // First fetch after reset.
      step(0, 0, '0);
      chk("first_pc4", IF_ID_PCPlus4, 32'h44);
      chk("first_pc", PC, 32'h44);
      chk("first_valid", {31'b0, IF_ID_Valid}, 32'd1);

      // Land on 0x100 with a valid slot, then stall 3 cycles.
      step(0, 1, 32'h0000_00FC);
      step(0, 0, '0);
      chk("at_100", PC, 32'h100);
      for (int i = 0; i < 3; i++) begin
         step(1, 0, '0);
         chk("stall_hold_pc", PC, 32'h100);
         chk("stall_hold_pc4", IF_ID_PCPlus4, 32'h100);
      end
      step(0, 0, '0);
      chk("stall_release_pc", PC, 32'h104);

      // Plain redirect.
      step(0, 1, 32'h200);
      chk("br_pc", PC, 32'h200);
      chk("br_valid", {31'b0, IF_ID_Valid}, 32'd0);
      chk("br_bubble", {31'b0, ID_EX_Bubble}, 32'd1);
      step(0, 1, 32'h999);   // stale branch during the flush slot
      chk("br_next_pc4", IF_ID_PCPlus4, 32'h204);
      chk("br_next_pc", PC, 32'h204);

      // Stall beats branch; release with branch still high redirects.
      step(1, 1, 32'h300);
      step(1, 1, 32'h300);
      chk("stall_br_hold", PC, 32'h204);
      step(0, 1, 32'h300);
      chk("stall_br_release", PC, 32'h300);
      // Stall against the squashed slot is ignored.
      step(1, 0, '0);
      chk("flush_stall_ignored", PC, 32'h304);

      // PC wrap and unaligned target pass-through.
      step(0, 1, 32'hFFFF_FFFC);
      step(0, 0, '0);
      chk("wrap_pc", PC, 32'h0);
      chk("wrap_pc4", IF_ID_PCPlus4, 32'h0);
      step(0, 1, 32'h203);
      chk("lowbits_pc", PC, 32'h203);
      step(0, 0, '0);
      chk("lowbits_next", PC, 32'h207);

      // Watchdog: sets on the 15th stalled edge, sticky across release.
      for (int i = 0; i < 20; i++) begin
         step(1, 0, '0);
         chk("timeout_ramp", {31'b0, StallTimeout}, (i >= MAXS - 1) ? 32'd1 : 32'd0);
      end
      step(0, 0, '0);
      chk("timeout_sticky", {31'b0, StallTimeout}, 32'd1);

      // Reset mid-stall and mid-flush.
      step(1, 0, '0);
      do_reset();
      step(0, 1, 32'h500);
      do_reset();
      step(0, 0, '0);
      chk("post_reset_pc", PC, 32'h44);

      // Randomized traffic against the model.
      for (int i = 0; i < 400; i++) begin
         bit s, b;
         logic [31:0] t;
         s = ($urandom_range(0, 99) < 35);
         b = ($urandom_range(0, 99) < 25);
         t = $urandom;
         if ($urandom_range(0, 3) != 0) t[1:0] = 2'b00;
         step(s, b, t);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nfail);
      $finish;
   end
endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Fetch-stage controller for the 5-stage MIPS pipeline: owns the PC register and the IF/ID pipeline register, and applies the hazard unit's stall request and decode-stage branch redirects to them. It sits directly upstream of the hazard unit, whose stall output feeds back into this block. Branches resolve in decode. There is no delay slot: the instruction fetched behind a taken branch is squashed.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- MAX_STALL, 15, consecutive stall cycles before the watchdog flag is set (1..255).

Ports:
- Clk  input  1  rising-edge clock.
- Reset  input  1  reset; asynchronous, active-low (0 = reset).
- Stall  input  1  hazard unit FlushSignal; 1 = hold fetch and insert a bubble into ID/EX.
- BranchTaken  input  1  decode-stage branch/jump resolved taken.
- BranchTarget  input  32  redirect address, valid when BranchTaken=1.
- Instruction  input  32  instruction memory data at PC (combinational read).
- PC  output  32  current fetch address.
- IF_ID_Instruction  output  32  IF/ID register instruction.
- IF_ID_PCPlus4  output  32  IF/ID register PC+4.
- IF_ID_Valid  output  1  IF/ID holds a real instruction.
- ID_EX_Bubble  output  1  force ID/EX control signals to zero this cycle.
- StallTimeout  output  1  sticky watchdog flag.
- StallCycles  output  32  performance counter (see Configuration).
- FlushCount  output  32  performance counter (see Configuration).

## Operation
- Effective stall: StallQ = Stall & IF_ID_Valid. Stall requests against a squashed slot are ignored, because a nop with rs=rt=0 would otherwise falsely match.
- Priority each cycle: StallQ > BranchTaken > normal fetch.
- FSM states are RUN, STALL and FLUSH. The state is reset to RUN.
- RUN, StallQ=1:
  - PC, IF_ID and counters other than the stall counter hold.
  - The stall counter increments.
  - Next state is STALL.
- RUN, BranchTaken=1 with StallQ=0:
  - PC <= BranchTarget.
  - IF_ID_Instruction <= 0, IF_ID_PCPlus4 <= 0, IF_ID_Valid <= 0.
  - Next state is FLUSH.
- RUN, otherwise:
  - PC <= PC+4.
  - IF_ID <= {Instruction, PC+4}, IF_ID_Valid <= 1.
- STALL:
  - Stays in STALL while StallQ=1, holding everything.
  - When StallQ=0, the stall counter clears and the block behaves exactly as RUN for that cycle. A branch released in that same cycle therefore redirects, and the next state is FLUSH or RUN accordingly.
- FLUSH:
  - BranchTaken is ignored, since decode holds a nop.
  - Normal fetch from the target: PC <= PC+4, IF_ID <= {Instruction, PC+4}, valid 1.
  - Next state is RUN.
- ID_EX_Bubble = StallQ | ~IF_ID_Valid. This is combinational so it blocks ID/EX in the same cycle as the hazard.
- Stall counter is 8 bits and saturates at MAX_STALL. When it reaches MAX_STALL, StallTimeout is set. The flag is cleared only by Reset. The flag does not force a release.
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 wraps to 0. The low two bits of BranchTarget are passed through unchanged.

## Timing
- All registers update on the rising edge of Clk.
- Reset assertion is asynchronous.
- Reset values:
  - PC = RESET_PC.
  - IF_ID_Instruction = 0, IF_ID_PCPlus4 = 0, IF_ID_Valid = 0.
  - StallTimeout = 0, StallCycles = 0, FlushCount = 0.
  - Because IF_ID_Valid = 0 during reset, ID_EX_Bubble = 1.
- First real instruction: IF_ID_Valid rises on the first edge after Reset deasserts.
- Stall-to-hold latency is 0 cycles. A Stall seen before edge N means PC and IF_ID do not change at edge N.
- Branch penalty is 1 bubble cycle. The branch is seen before edge N; the target is in IF_ID after edge N+1.
- Reset mid-stall or mid-flush returns to RUN with reset values. Pending redirects are lost.

## Configuration
- STALL_PERF_EN defined:
  - StallCycles increments on every cycle with StallQ=1.
  - FlushCount increments on every redirect, i.e. each RUN→FLUSH transition or STALL release with a branch.
  - Both are 32-bit, wrap at 2^32, and reset to 0.
- STALL_PERF_EN undefined:
  - The counters are not instantiated.
  - StallCycles and FlushCount are driven constant 0.
  - All other behaviour is identical.

## Test plan
- Reset with RESET_PC=32'h0000_0040 → PC=0x40 and ID_EX_Bubble=1. After the first edge: IF_ID_PCPlus4=0x44, IF_ID_Valid=1, and PC=0x44.
- Valid slot, Stall=1 held for 3 cycles at PC=0x100 → PC stays 0x100 and IF_ID is unchanged for 3 edges, ID_EX_Bubble=1 throughout. On release, PC=0x104. With STALL_PERF_EN, StallCycles=3.
- BranchTaken=1, BranchTarget=0x200 in RUN → next edge: PC=0x200, IF_ID_Valid=0, ID_EX_Bubble=1. Following edge: IF_ID_PCPlus4=0x204, PC=0x204. FlushCount=1.
- Stall=1 and BranchTaken=1 together → hold with no redirect. Drop Stall while BranchTaken stays 1 → PC=target on that edge and state goes to FLUSH.
- Stall=1 while IF_ID_Valid=0 (FLUSH slot) → ignored: PC advances and the stall counter stays 0.
- Stall held for 20 cycles with MAX_STALL=15 → StallTimeout rises after the 15th stalled edge and stays high after release until Reset=0.
